// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the core's single SRAM-like memory bus between instruction fetch
//   and the data-memory stage. Only one transaction is outstanding at a time.
//   The winning request is latched so the bus fields stay stable, and the
//   completion goes back only to the requester that owns the transaction.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   inst_req/addr       : fetch request (always a word read)
//   inst_rdata/data_ok  : fetch response, rdata qualified by data_ok
//   data_req/wr/size/wstrb/addr/wdata : data-side request, lane-aligned
//   data_rdata/data_ok  : raw load word, qualified by data_ok
//   bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata : bus request
//   bus_addr_ok, bus_data_ok, bus_rdata : bus handshakes and read data
//   busy                : a transaction is in progress
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [1:0] state;
    logic       owner;      // 0 = inst, 1 = data
    logic [3:0] streak;     // consecutive data grants while inst waited
    logic       grant_inst;
    logic       grant_data;
    logic       done;

    // Data wins ties until it has taken STREAK_MAX grants past a waiting fetch.
    always_comb begin
        grant_inst = inst_req && (!data_req || (streak == STREAK_MAX));
        grant_data = data_req && !grant_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            streak    <= '0;
            bus_wr    <= 1'b0;
            bus_size  <= '0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_inst) begin
                        bus_wr    <= 1'b0;
                        bus_size  <= 2'b10;
                        bus_wstrb <= '0;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                        owner     <= 1'b0;
                        streak    <= '0;
                        state     <= S_ADDR;
                    end else if (grant_data) begin
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_wstrb <= data_wstrb;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        owner     <= 1'b1;
                        // Only a grant that bypassed a waiting fetch extends the streak.
                        if (!inst_req)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 4'd1;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus_addr_ok)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (bus_data_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // bus_data_ok only completes a transaction while waiting in DATA.
    assign done         = (state == S_DATA) && bus_data_ok;
    assign inst_data_ok = done && !owner;
    assign data_data_ok = done && owner;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign bus_req      = (state == S_ADDR);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench plays both requesters and
//   the bus. A transaction-level model predicts each grant winner from the
//   arbitration rules and a data-streak count, and the latched bus fields and
//   completion pulses are checked against it cycle by cycle.
module tb_mem_arbiter;

    localparam int unsigned MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned streak;        // model: data grants taken past a waiting fetch
    logic [5:0]  order;         // 1 = data grant, indexed by grant number
    int unsigned n_grants;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch addresses live below 0x8000_0000 and data addresses above it.
    task automatic new_inst();
        inst_req  = 1'b1;
        inst_addr = $urandom() & 32'h7fff_fffc;
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom() | 32'h8000_0000;
        data_wstrb = data_wr ? 4'($urandom_range(1, 15)) : 4'h0;
        data_wdata = $urandom();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_breq"}, 32'(bus_req), 32'd0);
        check({tag, "_iok"}, 32'(inst_data_ok), 32'd0);
        check({tag, "_dok"}, 32'(data_data_ok), 32'd0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        tick();
        check_idle("rst");
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, 32'd0);
        tick();
        rst    = 1'b0;
        streak = 0;
    endtask

    // One transaction starting from an IDLE cycle whose requests are already
    // driven. keep: 0 = owner drops its request, 1 = reissues, 2 = random.
    task automatic do_txn(input int unsigned aw, input int unsigned dw,
                          input logic [31:0] rd, input int unsigned keep);
        logic        winst;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;

        #1;
        check_idle("idle");
        winst = inst_req && (!data_req || streak == MAXS);
        if (winst) begin
            e_wr = 1'b0; e_size = 2'b10; e_wstrb = 4'h0;
            e_addr = inst_addr; e_wdata = 32'd0;
            streak = 0;
        end else begin
            e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
            e_addr = data_addr; e_wdata = data_wdata;
            streak = inst_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end
        if (n_grants < 6) order[n_grants] = !winst;
        n_grants++;
        tick();

        for (int unsigned k = 0; k <= aw; k++) begin
            if (winst && !data_req && $urandom_range(0, 3) == 0) new_data();
            if (!winst && !inst_req && $urandom_range(0, 3) == 0) new_inst();
            bus_addr_ok = (k == aw);
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom();
            #1;
            check("addr_breq", 32'(bus_req), 32'd1);
            check("addr_busy", 32'(busy), 32'd1);
            check("addr_addr", bus_addr, e_addr);
            check("addr_wdata", bus_wdata, e_wdata);
            check("addr_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, e_wr, e_size, e_wstrb});
            check("addr_iok", 32'(inst_data_ok), 32'd0);
            check("addr_dok", 32'(data_data_ok), 32'd0);
            tick();
        end

        for (int unsigned k = 0; k <= dw; k++) begin
            if (winst && !data_req && $urandom_range(0, 3) == 0) new_data();
            if (!winst && !inst_req && $urandom_range(0, 3) == 0) new_inst();
            bus_data_ok = (k == dw);
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_rdata   = (k == dw) ? rd : $urandom();
            #1;
            check("data_breq", 32'(bus_req), 32'd0);
            check("data_busy", 32'(busy), 32'd1);
            check("data_iok", 32'(inst_data_ok), 32'((k == dw) && winst));
            check("data_dok", 32'(data_data_ok), 32'((k == dw) && !winst));
            if (k == dw)
                check("rdata", winst ? inst_rdata : data_rdata, rd);
            tick();
        end

        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (keep == 1 || (keep == 2 && $urandom_range(0, 1) == 1)) begin
            if (winst) new_inst(); else new_data();
        end else begin
            if (winst) inst_req = 1'b0; else data_req = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        streak = 0; order = '0; n_grants = 0;
        do_reset();

        // Single load, zero wait states.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_wstrb = 4'h0;
        data_addr = 32'h0000_0100; data_wdata = 32'd0;
        do_txn(0, 0, 32'hDEAD_BEEF, 0);

        // Simultaneous fetch and store: data first, then fetch.
        inst_req = 1'b1; inst_addr = 32'h0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00; data_wstrb = 4'b0100;
        data_addr = 32'h0000_0200; data_wdata = 32'h00AB_0000;
        do_txn(0, 0, $urandom(), 0);
        data_req = 1'b0;
        do_txn(0, 0, $urandom(), 0);

        // Wait states: addr_ok after 3 extra cycles, data_ok after 2.
        new_data();
        do_txn(3, 2, $urandom(), 0);

        // Starvation guard: both requesters stay busy from a fresh reset.
        do_reset();
        n_grants = 0;
        new_inst();
        new_data();
        for (int i = 0; i < 6; i++)
            do_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom(), 1);
        check("grant_order", 32'(order), 32'b101111);

        // Reset while waiting in DATA; a late data_ok must be ignored.
        do_reset();
        new_data();
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        data_req = 1'b0;
        streak = 0;
        bus_data_ok = 1'b1;
        #1;
        check_idle("mid_late");
        tick();
        bus_data_ok = 1'b0;
        #1;
        check_idle("mid_after");

        // Randomized traffic with stray handshakes in IDLE.
        for (int t = 0; t < 300; t++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) new_inst();
            if (!data_req && $urandom_range(0, 3) != 0) new_data();
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom();
            if (inst_req || data_req) begin
                do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom(), 2);
            end else begin
                #1;
                check_idle("rand_idle");
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
